// File: rtl/rgb_stream_arbiter.sv
// Packet-aware round-robin arbiter that shares one registered RGB output stage between two
// valid/ready pixel requesters. Long packets are split into segments of at most MAX_BURST beats.
module rgb_stream_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] in0_r,
  input  logic [DATA_WIDTH-1:0] in0_g,
  input  logic [DATA_WIDTH-1:0] in0_b,
  input  logic                  in0_valid,
  input  logic                  in0_last,
  output logic                  in0_ready,

  input  logic [DATA_WIDTH-1:0] in1_r,
  input  logic [DATA_WIDTH-1:0] in1_g,
  input  logic [DATA_WIDTH-1:0] in1_b,
  input  logic                  in1_valid,
  input  logic                  in1_last,
  output logic                  in1_ready,

  output logic [DATA_WIDTH-1:0] out_r,
  output logic [DATA_WIDTH-1:0] out_g,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,

  output logic                  grant_idx,
  output logic                  locked
);

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q;
  logic                  rr_q;
  logic                  grant_q;
  logic [7:0]            cnt_q;
  logic [DATA_WIDTH-1:0] out_r_q, out_g_q, out_b_q;
  logic                  out_valid_q, out_last_q;

  logic                  load;
  logic                  sel;
  logic                  cur;
  logic                  cur_valid;
  logic                  cur_last;
  logic [DATA_WIDTH-1:0] cur_r, cur_g, cur_b;
  logic                  xfer;
  logic [7:0]            cnt_next;
  logic                  seg_end;

  always_comb begin
    load = !out_valid_q || out_ready;

    // Idle selection: a lone valid requester wins, a tie goes to the one not served last.
    sel = !rr_q;
    if (in0_valid && !in1_valid) begin
      sel = 1'b0;
    end else if (!in0_valid && in1_valid) begin
      sel = 1'b1;
    end

    cur = (state_q == StLocked) ? grant_q : sel;

    cur_valid = cur ? in1_valid : in0_valid;
    cur_last  = cur ? in1_last  : in0_last;
    cur_r     = cur ? in1_r     : in0_r;
    cur_g     = cur ? in1_g     : in0_g;
    cur_b     = cur ? in1_b     : in0_b;

    in0_ready = load && !cur;
    in1_ready = load && cur;

    xfer = load && cur_valid;

    // Beats in the segment including the one transferring now.
    cnt_next = (state_q == StLocked) ? cnt_q + 8'd1 : 8'd1;
    seg_end  = cur_last || (cnt_next == BurstMax);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_q        <= 1'b1;
      grant_q     <= 1'b0;
      cnt_q       <= 8'd0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= xfer;
        if (xfer) begin
          out_r_q    <= cur_r;
          out_g_q    <= cur_g;
          out_b_q    <= cur_b;
          out_last_q <= seg_end;
        end
      end

      if (xfer) begin
        grant_q <= cur;
        if (seg_end) begin
          state_q <= StIdle;
          rr_q    <= cur;
          cnt_q   <= 8'd0;
        end else begin
          state_q <= StLocked;
          cnt_q   <= cnt_next;
        end
      end
    end
  end

  assign out_r     = out_r_q;
  assign out_g     = out_g_q;
  assign out_b     = out_b_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign grant_idx = grant_q;
  assign locked    = (state_q == StLocked);

endmodule

// File: doc/rgb_stream_arbiter.md
Name: rgb_stream_arbiter

Overview:
- Shares one registered RGB pixel output stage between two RGB pixel requesters, each a stream of 8-bit r/g/b beats.
- Packet-aware round-robin arbiter using valid/ready handshakes.
- Holds a grant for a whole packet, up to a burst limit; at the limit the packet is split into segments.
- Sits in front of the per-channel pixel registers that feed a single downstream consumer.

Parameters:
- DATA_WIDTH, 8, width of each colour channel (r, g, b).
- MAX_BURST, 16, maximum beats per granted segment; range 1..255.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in0_r, in0_g, in0_b  input  DATA_WIDTH each  requester 0 pixel channels.
- in0_valid  input  1  requester 0 beat valid.
- in0_last  input  1  requester 0 end-of-packet marker.
- in0_ready  output  1  requester 0 beat accepted.
- in1_r, in1_g, in1_b / in1_valid / in1_last / in1_ready  same as requester 0, for requester 1.
- out_r, out_g, out_b  output  DATA_WIDTH each  registered output pixel.
- out_valid  output  1  output beat valid.
- out_last  output  1  end of output segment.
- out_ready  input  1  downstream accepts the output beat.
- grant_idx  output  1  index of the currently or most recently granted requester.
- locked  output  1  a segment is in progress.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - out_valid=0, out_r/g/b=0, out_last=0.
  - locked=0, grant_idx=0, beat counter=0.
  - round-robin pointer rr=1, so requester 0 wins the first tie.
- Output register
  - Holds one beat. load = !out_valid | out_ready.
  - Latency: an input beat accepted in cycle N appears on out_* in cycle N+1.
  - out_valid falls after a cycle with out_ready=1 and no accepted input. Full throughput is one beat per cycle.
  - While out_valid=1 and out_ready=0, out_* are held stable.
- State machine: IDLE (locked=0) and LOCKED (locked=1).
- IDLE
  - Selection is combinational among valid requesters:
    - only one valid: select it;
    - both valid: select !rr.
  - Only the selected requester sees inX_ready = load. The other requester's ready = 0.
  - On a transfer (valid & ready): grant_idx <= winner.
    - If in_last=1, or MAX_BURST==1: stay IDLE, rr <= winner.
    - Else: go LOCKED, beat counter <= 1.
- LOCKED
  - in[grant_idx]_ready = load; the other ready = 0.
  - No rearbitration, even if the other requester is valid.
  - On a transfer:
    - beat counter increments;
    - if in_last=1 or the counter reaches MAX_BURST, go IDLE, rr <= grant_idx, counter <= 0.
  - A granted requester dropping valid mid-segment leaves the grant in place. Bubbles are allowed.
- out_last = in_last of the transferred beat OR the beat completes MAX_BURST (forced segment end).
- No idle cycle between segments. An IDLE selection can transfer in the same cycle the previous segment's final beat leaves the output register, provided load=1.
- Round-robin fairness: after a segment from X ends, with both valid, the other requester wins.
- Reset mid-segment: any beat in flight is dropped; the arbiter returns to IDLE with rr=1.
- The ready signals depend combinationally on out_ready and the valids, never on themselves. No combinational valid-to-valid path.

Test Plan:
- Single requester: in0 sends 3 beats (r/g/b=0x10/0x20/0x30 ... last on beat 3) with out_ready=1.
  -> out beats identical, one cycle later, out_last on the 3rd, grant_idx=0; locked=1 after beat 1 and 0 after beat 3.
- Tie after reset: both requesters valid with 2-beat packets (in0 data 0xA*, in1 0xB*).
  -> in0's packet is output first, then in1's, with no interleave and no gap cycle.
- Lock hold: in1 holds valid for its whole 4-beat packet while in0 raises valid at beat 2.
  -> in0_ready=0 until in1's last beat transfers; in0 is granted the next cycle.
- Burst split, MAX_BURST=4: in0 sends a 6-beat packet with in1 also valid.
  -> out_last on in0's beat 4; in1's packet follows; then in0 resumes with beats 5-6, last on beat 6.
- Backpressure: out_ready=0 for 3 cycles mid-packet.
  -> out_* stable; in0_ready=0 from the cycle after the output register fills; no beat lost or duplicated.
- Async reset while LOCKED with out_valid=1.
  -> out_valid, locked, grant_idx and out_* are 0 immediately. After release, a tie grants in0.
